// File: rtl/cw_reader_pkg.sv
// Shared definitions for the ChipWatcher trace read-back path: FSM state codes,
// CRC-16-CCITT constants and a constant clog2 used to size counters.
package cw_reader_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_SHIFT = 3'd4;
  localparam logic [2:0] ST_CRC   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Never returns less than 1 so the result can always size a counter.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/cw_sample_reader_crc.sv
// Serial CRC-16-CCITT, one bit per clock, MSB-first register update.
// Exposes the post-update value so the caller can grab the CRC including the current bit.
module cw_crc16_serial
  import cw_reader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_din,
  output logic [15:0] o_crc,
  output logic [15:0] o_crc_next
);

  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb       = r_crc[15] ^ i_din;
  assign o_crc_next = {r_crc[14:0], 1'b0} ^ (w_fb ? CRC_POLY : 16'h0000);
  assign o_crc      = r_crc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= CRC_INIT;
    end else if (i_clr) begin
      r_crc <= CRC_INIT;
    end else if (i_en) begin
      r_crc <= o_crc_next;
    end
  end

endmodule

// File: rtl/cw_sample_reader.sv
// Unloads the ChipWatcher trace RAM oldest-first onto a JTAG data chain, LSB first.
// Define CW_READ_CRC_EN to append a 16-bit CRC-16-CCITT of the data stream before DONE.
module cw_sample_reader
  import cw_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 40,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 1024,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  jtck,
  input  logic                  jrstn,
  input  logic                  jsel,
  input  logic                  jshift,
  input  logic                  jupdate,
  input  logic                  cap_done,
  input  logic [ADDR_WIDTH-1:0] cap_wr_ptr,
  output logic                  rd_ce,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  jtdo,
  output logic                  rd_busy,
  output logic                  rd_done
);

  localparam int WCNT_W = clog2(DEPTH + 1);
  localparam int BCNT_W = clog2(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [WCNT_W-1:0]     LAST_WORD = WCNT_W'(DEPTH - 1);
  localparam logic [BCNT_W-1:0]     LAST_BIT  = BCNT_W'(DATA_WIDTH - 1);

  logic [2:0]             r_state;
  logic                   r_rd_ce;
  logic [ADDR_WIDTH-1:0]  r_rd_addr;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic [DATA_WIDTH-1:0]  r_prefetch;
  logic                   r_pf_valid;
  logic [WCNT_W-1:0]      r_word_cnt;
  logic [BCNT_W-1:0]      r_bit_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic [RAM_LATENCY-1:0] r_ce_pipe;

  logic                  w_start;
  logic                  w_shift_en;
  logic                  w_data_valid;
  logic                  w_word_end;
  logic                  w_last_word;
  logic                  w_do_shift;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  assign w_start      = jupdate & jsel & cap_done;
  assign w_shift_en   = jsel & jshift;
  assign w_data_valid = r_ce_pipe[RAM_LATENCY-1];
  assign w_word_end   = (r_bit_cnt == LAST_BIT);
  assign w_last_word  = (r_word_cnt == LAST_WORD);
  assign w_next_addr  = (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + 1'b1;
  // At a word boundary the shift stalls until the next word has been prefetched.
  assign w_do_shift   = (r_state == ST_SHIFT) & w_shift_en &
                        (~w_word_end | w_last_word | r_pf_valid);

  assign rd_ce   = r_rd_ce;
  assign rd_addr = r_rd_addr;
  assign rd_busy = r_busy;
  assign rd_done = r_done;

`ifdef CW_READ_CRC_EN
  logic [15:0] r_crc_sr;
  logic [3:0]  r_crc_cnt;
  logic [15:0] w_crc;
  logic [15:0] w_crc_next;

  cw_crc16_serial u_crc (
    .i_clk      (jtck),
    .i_rst_n    (jrstn),
    .i_clr      (w_start),
    .i_en       (w_do_shift),
    .i_din      (r_shift[0]),
    .o_crc      (w_crc),
    .o_crc_next (w_crc_next)
  );

  // The CRC is captured on the last data bit so its first bit follows with no gap.
  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      r_crc_sr  <= '0;
      r_crc_cnt <= '0;
    end else if (w_do_shift && w_word_end && w_last_word) begin
      r_crc_sr  <= w_crc_next;
      r_crc_cnt <= '0;
    end else if (r_state == ST_CRC && w_shift_en) begin
      r_crc_sr  <= r_crc_sr >> 1;
      r_crc_cnt <= r_crc_cnt + 1'b1;
    end
  end

  assign jtdo = (r_state == ST_CRC) ? r_crc_sr[0] : r_shift[0];
`else
  assign jtdo = r_shift[0];
`endif

  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      r_state    <= ST_IDLE;
      r_rd_ce    <= 1'b0;
      r_rd_addr  <= '0;
      r_shift    <= '0;
      r_prefetch <= '0;
      r_pf_valid <= 1'b0;
      r_word_cnt <= '0;
      r_bit_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ce_pipe  <= '0;
    end else begin
      r_rd_ce      <= 1'b0;
      r_ce_pipe[0] <= r_rd_ce;
      for (int i = 1; i < RAM_LATENCY; i++) r_ce_pipe[i] <= r_ce_pipe[i-1];

      // Aborts and restarts flush the read tracking so late RAM data is never used.
      if (r_busy && !cap_done) begin
        r_state    <= ST_IDLE;
        r_busy     <= 1'b0;
        r_done     <= 1'b0;
        r_shift    <= '0;
        r_pf_valid <= 1'b0;
        r_ce_pipe  <= '0;
      end else if (w_start) begin
        r_state    <= ST_FETCH;
        r_rd_ce    <= 1'b1;
        r_rd_addr  <= cap_wr_ptr;
        r_word_cnt <= '0;
        r_bit_cnt  <= '0;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
        r_shift    <= '0;
        r_pf_valid <= 1'b0;
        r_ce_pipe  <= '0;
      end else begin
        case (r_state)
          ST_FETCH: r_state <= ST_WAIT;
          ST_WAIT: begin
            if (w_data_valid) begin
              r_prefetch <= rd_data;
              r_state    <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            r_shift   <= r_prefetch;
            r_bit_cnt <= '0;
            r_rd_addr <= w_next_addr;
            r_rd_ce   <= (int'(r_word_cnt) + 1 < DEPTH);
            r_state   <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (w_data_valid) begin
              r_prefetch <= rd_data;
              r_pf_valid <= 1'b1;
            end
            if (w_do_shift) begin
              if (!w_word_end) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end else if (w_last_word) begin
                r_shift    <= '0;
                r_word_cnt <= r_word_cnt + 1'b1;
`ifdef CW_READ_CRC_EN
                r_state    <= ST_CRC;
`else
                r_state    <= ST_DONE;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
`endif
              end else begin
                r_shift    <= r_prefetch;
                r_pf_valid <= 1'b0;
                r_bit_cnt  <= '0;
                r_word_cnt <= r_word_cnt + 1'b1;
                r_rd_addr  <= w_next_addr;
                r_rd_ce    <= (int'(r_word_cnt) + 2 < DEPTH);
              end
            end
          end
`ifdef CW_READ_CRC_EN
          ST_CRC: begin
            if (w_shift_en && r_crc_cnt == 4'd15) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/cw_sample_reader.md
Name: cw_sample_reader

Overview:
- Read-back end of the ChipWatcher capture path.
- The capture side writes sample words into the trace RAM through wt_ce/wt_en/wt_addr. This block reads those words back, oldest first, once capture is done.
- It serialises each word onto a JTAG data chain, clocked by jtck, so the host can unload the trace.
- It sits between the trace RAM read port and the JTAG scan mux, alongside the watcher control logic.

Parameters:
- DATA_WIDTH, 40, captured sample width in bits (equal to the bus node count).
- ADDR_WIDTH, 16, trace RAM address width (matches wt_addr).
- DEPTH, 1024, number of valid sample words in the RAM; must be ≤ 2^ADDR_WIDTH.
- RAM_LATENCY, 1, read latency from rd_ce to rd_data valid; allowed values 1 or 2.

Ports:
- jtck  in  1  JTAG clock; the block's only clock.
- jrstn  in  1  asynchronous active-low reset.
- jsel  in  1  this data chain is selected by jscan decode.
- jshift  in  1  JTAG Shift-DR for the selected chain.
- jupdate  in  1  JTAG Update-DR pulse (one jtck cycle).
- cap_done  in  1  capture complete; level, static while reading.
- cap_wr_ptr  in  ADDR_WIDTH  next write address at capture end, i.e. the oldest sample.
- rd_ce  out  1  RAM read enable.
- rd_addr  out  ADDR_WIDTH  RAM read address.
- rd_data  in  DATA_WIDTH  RAM read data.
- jtdo  out  1  serial data out, LSB of the current word first.
- rd_busy  out  1  unload in progress.
- rd_done  out  1  all DEPTH words shifted; sticky until the next start.

Behaviour:
- Reset values: rd_ce=0, rd_addr=0, jtdo=0, rd_busy=0, rd_done=0. All counters and both registers (shift, prefetch) are cleared.
- States:
  - IDLE: on jupdate & jsel & cap_done, go to FETCH; set rd_busy=1 and rd_done=0; load rd_addr=cap_wr_ptr; word_cnt=0.
  - jupdate & jsel with cap_done=0 is ignored and the block stays in IDLE.
  - FETCH: assert rd_ce for exactly one cycle; go to WAIT.
  - WAIT: wait RAM_LATENCY cycles, then capture rd_data into the prefetch register and go to LOAD.
  - LOAD: copy prefetch into the shift register; bit_cnt=0; increment rd_addr modulo DEPTH; go to SHIFT.
  - LOAD also issues the next rd_ce immediately if word_cnt+1 < DEPTH, so the following word is prefetched while the current one shifts.
  - SHIFT: on each jtck with jsel & jshift, shift the register right by one and increment bit_cnt.
  - jtdo always equals shift_reg[0].
  - With jshift=0 the shift register holds and no bit is lost.
- Word boundary:
  - When bit_cnt=DATA_WIDTH-1 and a shift occurs, the next word is loaded from prefetch in the same cycle and word_cnt increments. This gives a gap-free bitstream.
  - If prefetch is not yet valid at the boundary, jshift is ignored until it is. This can only happen at RAM_LATENCY=2 with back-to-back shifting faster than allowed, which is a documented host constraint.
- Address wrap: rd_addr wraps from DEPTH-1 to 0.
- Last word: after the last bit of word DEPTH-1 is shifted, go to DONE. rd_busy=0, rd_done=1, jtdo=0.
- DONE: a new start (jupdate & jsel & cap_done) restarts from cap_wr_ptr.
- jupdate while busy aborts the current unload and restarts from cap_wr_ptr on the next cycle. Partial data is discarded.
- cap_done falling mid-unload aborts to IDLE with rd_busy=0 and rd_done=0.
- Asynchronous reset mid-operation returns to IDLE with all outputs at their reset values.
- Counter widths: word_cnt is clog2(DEPTH+1) bits; bit_cnt is clog2(DATA_WIDTH) bits.

Optional Feature:
- Macro: CW_READ_CRC_EN.
- When defined:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF) is updated on every shifted data bit.
  - After the last word, the block enters a CRC state and shifts out 16 CRC bits, LSB first, before DONE.
  - rd_busy stays high through the CRC bits.
- When undefined: there is no CRC state or logic; DONE follows the last data bit directly.

Decomposition:
- Shared package cw_reader_pkg holds:
  - the state enum (IDLE, FETCH, WAIT, LOAD, SHIFT, CRC, DONE);
  - the CRC polynomial and init constants;
  - a clog2 function.
- One sub-module: cw_crc16_serial, a one-bit-per-cycle CRC with enable and clear. It is instantiated only under CW_READ_CRC_EN.

Test Plan:
- Basic unload:
  - Setup: DATA_WIDTH=8, DEPTH=4, RAM preloaded 0x11,0x22,0x33,0x44; cap_wr_ptr=0; start, then 32 shifts.
  - Required: jtdo stream equals the bytes 0x11,0x22,0x33,0x44, each LSB first; rd_done=1 after bit 32; rd_busy=0.
- Wrap-around:
  - Setup: same RAM, cap_wr_ptr=2.
  - Required: word order 0x33,0x44,0x11,0x22; rd_addr sequence 2,3,0,1.
- Stalled shifting:
  - Setup: jshift deasserted for 5 cycles mid-word.
  - Required: no bits lost or duplicated; stream identical to the basic unload.
- Start ignored and mid-unload restart:
  - Step 1: start with cap_done=0. Required: rd_busy stays 0 and no rd_ce.
  - Step 2: jupdate after 10 bits of a valid unload. Required: restart from cap_wr_ptr and a full 32-bit stream follows.
- Reset during SHIFT:
  - Stimulus: assert jrstn=0 mid-word.
  - Required: rd_ce=0, jtdo=0, rd_busy=0, rd_done=0 immediately; a clean unload works after release.
- CRC enabled (CW_READ_CRC_EN, basic RAM contents):
  - Required: 16 extra bits after the data equal the reference-model CRC-16-CCITT of the 32-bit stream; rd_done rises after bit 48.
